div_share_ctrl: RTL

- Shares one sequential radix-2 divider among NREQ requesters.
- Round-robin arbitration; one operation in flight at a time.
- Drives the divider's start/operand inputs, captures its quotient/remainder on done, and returns the result with the requester id over a valid/ready response channel.
- Divide-by-zero is resolved locally without occupying the divider.
- Sits between client engines and the divider instance in the arithmetic subsystem.

---
 rtl/arith_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/div_share_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared types and constants for the arithmetic subsystem's divider sharing logic.
package arith_pkg;

    // Default operand/result width of the shared radix-2 divider.
    localparam int unsigned DIV_WIDTH = 32;

    // Quotient reported for a divide-by-zero at the default width.
    localparam logic [DIV_WIDTH-1:0] DZ_QUOTIENT = '1;

    // Sharing controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } div_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or above ptr, with wrap.
module rr_arbiter
    import arith_pkg::*;
#(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  gnt_id_o,
    output logic            any_o
);

    logic [IDW-1:0] idx;
    logic           found;

    // Scan requesters starting at ptr_i; the first active one wins.
    always_comb begin
        gnt_o    = '0;
        gnt_id_o = '0;
        idx      = '0;
        found    = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = IDW'((32'(ptr_i) + k) % NREQ);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                gnt_id_o   = idx;
                found      = 1'b1;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/div_share_ctrl.sv
// Shares one sequential divider among NREQ requesters with round-robin grant and a valid/ready response.
module div_share_ctrl
    import arith_pkg::*;
#(
    parameter  int unsigned WIDTH = DIV_WIDTH,
    parameter  int unsigned NREQ  = 4,
    localparam int unsigned IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_dividend,
    input  logic [NREQ*WIDTH-1:0] req_divisor,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_quotient,
    output logic [WIDTH-1:0]      rsp_remainder,
    output logic                  rsp_dz,
    output logic                  div_start,
    output logic [WIDTH-1:0]      div_dividend,
    output logic [WIDTH-1:0]      div_divisor,
    input  logic [WIDTH-1:0]      div_quotient,
    input  logic [WIDTH-1:0]      div_remainder,
    input  logic                  div_done
);

    localparam logic [WIDTH-1:0] DZ_Q = '1;

    div_state_e       state_q;
    logic [IDW-1:0]   rr_ptr_q;
    logic [IDW-1:0]   rr_ptr_d;
    logic             wait_first_q;
    logic             div_start_q;
    logic [WIDTH-1:0] div_dividend_q;
    logic [WIDTH-1:0] div_divisor_q;
    logic             rsp_valid_q;
    logic [IDW-1:0]   rsp_id_q;
    logic [WIDTH-1:0] rsp_quotient_q;
    logic [WIDTH-1:0] rsp_remainder_q;
    logic             rsp_dz_q;

    logic [NREQ-1:0]  arb_gnt;
    logic [IDW-1:0]   arb_id;
    logic             arb_any;
    logic             grant_c;
    logic [WIDTH-1:0] sel_dividend;
    logic [WIDTH-1:0] sel_divisor;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req_i    (req_valid),
        .ptr_i    (rr_ptr_q),
        .gnt_o    (arb_gnt),
        .gnt_id_o (arb_id),
        .any_o    (arb_any)
    );

    // Grants are only offered while idle; reset forces them off immediately.
    assign req_ready = (state_q == ST_IDLE && rst_n) ? arb_gnt : '0;
    assign grant_c   = (state_q == ST_IDLE) && arb_any;
    assign rr_ptr_d  = IDW'((32'(arb_id) + 32'd1) % NREQ);

    // Select the granted requester's operand pair.
    always_comb begin
        sel_dividend = '0;
        sel_divisor  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) begin
                sel_dividend = req_dividend[i*WIDTH +: WIDTH];
                sel_divisor  = req_divisor[i*WIDTH +: WIDTH];
            end
        end
    end

    // Controller FSM with all divider-side and response-side outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            rr_ptr_q        <= '0;
            wait_first_q    <= 1'b0;
            div_start_q     <= 1'b0;
            div_dividend_q  <= '0;
            div_divisor_q   <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_id_q        <= '0;
            rsp_quotient_q  <= '0;
            rsp_remainder_q <= '0;
            rsp_dz_q        <= 1'b0;
        end else begin
            div_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_c) begin
                        rsp_id_q <= arb_id;
                        rr_ptr_q <= rr_ptr_d;
                        if (sel_divisor == '0) begin
                            // Resolved locally; the divider is never started.
                            rsp_quotient_q  <= DZ_Q;
                            rsp_remainder_q <= sel_dividend;
                            rsp_dz_q        <= 1'b1;
                            rsp_valid_q     <= 1'b1;
                            state_q         <= ST_RESP;
                        end else begin
                            div_dividend_q <= sel_dividend;
                            div_divisor_q  <= sel_divisor;
                            div_start_q    <= 1'b1;
                            state_q        <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    wait_first_q <= 1'b1;
                    state_q      <= ST_WAIT;
                end
                ST_WAIT: begin
                    // div_done may still be the previous result on the first cycle.
                    if (wait_first_q) begin
                        wait_first_q <= 1'b0;
                    end else if (div_done) begin
                        rsp_quotient_q  <= div_quotient;
                        rsp_remainder_q <= div_remainder;
                        rsp_dz_q        <= 1'b0;
                        rsp_valid_q     <= 1'b1;
                        state_q         <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign div_start     = div_start_q;
    assign div_dividend  = div_dividend_q;
    assign div_divisor   = div_divisor_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_id        = rsp_id_q;
    assign rsp_quotient  = rsp_quotient_q;
    assign rsp_remainder = rsp_remainder_q;
    assign rsp_dz        = rsp_dz_q;

endmodule
